// File: rtl/edge_irq_ctrl_pkg.sv
// Shared definitions for the edge interrupt controller and its tick generator.
//  - FSM encodings for the controller state register.
//  - Default prescaler terminal count / width (10 ms tick at 100 MHz).
package edge_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2,
        ST_3    = 2'd3   // unused code; recovers to IDLE
    } state_t;

    localparam int TICK_MAX_DEF = 999999;
    localparam int CNT_W_DEF    = 20;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-clk tick every TICK_MAX+1 clocks.
// Shared with the switch debouncer.
// Ports:
//  clk   in   system clock
//  rst   in   synchronous active-high reset
//  clr   in   restart the count from 0 (next tick TICK_MAX+1 clk later)
//  tick  out  high while the count sits at TICK_MAX
module tick_gen
    import edge_irq_ctrl_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TICK_MAX = TICK_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TICK_MAX);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TMAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/edge_irq_ctrl.sv
// Rising-edge interrupt controller for a debounced level.
// Emits a one-clk edge pulse, holds an interrupt until acknowledged, then
// rejects edges for a tick-timed hold-off. Counts accepted and overrun
// edges (wrapping) and keeps a sticky overrun flag.
// Ports:
//  clk        in   system clock
//  rst        in   synchronous active-high reset
//  level_in   in   debounced level (already in clk domain)
//  int_ack    in   interrupt acknowledge (pulse or level)
//  ovr_clr    in   clears overrun (a same-clk set wins)
//  ped        out  registered one-clk rising-edge pulse
//  interrupt  out  interrupt request, held until ack
//  overrun    out  sticky: edge arrived while interrupt pending
//  event_cnt  out  count of accepted + overrun edges, wraps
module edge_irq_ctrl
    import edge_irq_ctrl_pkg::*;
#(
    parameter int TICK_MAX   = TICK_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int HOLD_TICKS = 2,
    parameter int EVT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             level_in,
    input  logic             int_ack,
    input  logic             ovr_clr,
    output logic             ped,
    output logic             interrupt,
    output logic             overrun,
    output logic [EVT_W-1:0] event_cnt
);

    // One spare bit so HOLD_TICKS itself is always representable.
    localparam int HC_W = $clog2(HOLD_TICKS + 1) + 1;
    localparam logic [HC_W-1:0] HOLD_N = HC_W'(HOLD_TICKS);

    state_t          state, state_nxt;
    logic            level_q;
    logic            rise;
    logic            tick;
    logic [HC_W-1:0] hold_cnt;
    logic            ovr_set, cnt_inc, hold_clr, hold_inc;

    assign rise = level_in & ~level_q;

    // Prescaler restarts on HOLD entry so the hold-off is measured from the ack.
    tick_gen #(
        .CNT_W   (CNT_W),
        .TICK_MAX(TICK_MAX)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (hold_clr),
        .tick(tick)
    );

    always_comb begin
        state_nxt = state;
        ovr_set   = 1'b0;
        cnt_inc   = 1'b0;
        hold_clr  = 1'b0;
        hold_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_PEND;
                    cnt_inc   = 1'b1;
                end
            end
            ST_PEND: begin
                // An edge here is lost but still counted and flagged,
                // even when it coincides with the ack.
                if (rise) begin
                    ovr_set = 1'b1;
                    cnt_inc = 1'b1;
                end
                if (int_ack) begin
                    state_nxt = ST_HOLD;
                    hold_clr  = 1'b1;
                end
            end
            ST_HOLD: begin
                // Exit test comes first so HOLD_TICKS=0 spends exactly one clk here.
                if (hold_cnt == HOLD_N) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    hold_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            level_q   <= 1'b0;
            ped       <= 1'b0;
            interrupt <= 1'b0;
            overrun   <= 1'b0;
            event_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            level_q   <= level_in;
            ped       <= rise;
            interrupt <= (state_nxt == ST_PEND);
            if (cnt_inc) begin
                event_cnt <= event_cnt + EVT_W'(1);
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
            if (hold_clr) begin
                hold_cnt <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + HC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_edge_irq_ctrl.sv
// Directed bench for edge_irq_ctrl (TICK_MAX=3, HOLD_TICKS=2, EVT_W=8).
// Stimulus pushes hand-computed expected output snapshots, tagged with the
// clock count they apply to; a monitor on the falling edge pops and compares.
module tb_edge_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       level_in;
    logic       int_ack;
    logic       ovr_clr;
    logic       ped;
    logic       interrupt;
    logic       overrun;
    logic [7:0] event_cnt;

    edge_irq_ctrl #(
        .TICK_MAX  (3),
        .CNT_W     (4),
        .HOLD_TICKS(2),
        .EVT_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .level_in (level_in),
        .int_ack  (int_ack),
        .ovr_clr  (ovr_clr),
        .ped      (ped),
        .interrupt(interrupt),
        .overrun  (overrun),
        .event_cnt(event_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       p;
        logic       i;
        logic       o;
        logic [7:0] c;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected outputs after the most recent rising edge.
    task automatic expect_out(input string nm, input logic p, input logic i,
                              input logic o, input logic [7:0] c);
        exp_t e;
        e.due = cyc; e.p = p; e.i = i; e.o = o; e.c = c;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares every snapshot due in this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if (e.due != cyc) begin
                $display("FAIL %s: snapshot for cycle %0d compared late at %0d", nm, e.due, cyc);
            end else if ({ped, interrupt, overrun, event_cnt} !== {e.p, e.i, e.o, e.c}) begin
                $display("FAIL %s: got ped=%b int=%b ovr=%b cnt=%0d, want ped=%b int=%b ovr=%b cnt=%0d",
                         nm, ped, interrupt, overrun, event_cnt, e.p, e.i, e.o, e.c);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; level_in = 1'b0; int_ack = 1'b0; ovr_clr = 1'b0;

        // 1: reset
        step(3);
        expect_out("reset", 0, 0, 0, 8'd0);
        rst = 1'b0;
        step();
        expect_out("idle_after_reset", 0, 0, 0, 8'd0);

        // 2: first edge, interrupt held without ack
        level_in = 1'b1;
        step();
        expect_out("first_edge", 1, 1, 0, 8'd1);
        step();
        expect_out("ped_one_clk", 0, 1, 0, 8'd1);
        step(20);
        expect_out("int_held", 0, 1, 0, 8'd1);

        // 3: ack, edges during hold-off are only pulsed
        int_ack = 1'b1;
        step();                         // edge m
        int_ack = 1'b0;
        expect_out("ack_drops_int", 0, 0, 0, 8'd1);
        level_in = 1'b0; step();        // m+1
        level_in = 1'b1; step();        // m+2
        expect_out("hold_edge1", 1, 0, 0, 8'd1);
        level_in = 1'b0; step();        // m+3
        level_in = 1'b1; step();        // m+4
        expect_out("hold_edge2", 1, 0, 0, 8'd1);
        level_in = 1'b0; step(7);       // m+5..m+11, HOLD ends at m+9
        expect_out("hold_over", 0, 0, 0, 8'd1);
        level_in = 1'b1; step();        // m+12
        expect_out("edge_after_hold", 1, 1, 0, 8'd2);

        // 4: overrun set / clear / set-wins-over-clear
        level_in = 1'b0; step();
        level_in = 1'b1; step();
        expect_out("overrun_set", 1, 1, 1, 8'd3);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        expect_out("overrun_clr", 0, 1, 0, 8'd3);
        level_in = 1'b0; step();
        level_in = 1'b1; ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        expect_out("set_beats_clr", 1, 1, 1, 8'd4);
        step();
        expect_out("overrun_sticky", 0, 1, 1, 8'd4);
        level_in = 1'b0; step();
        level_in = 1'b1; int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_out("edge_with_ack", 1, 0, 1, 8'd5);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        expect_out("overrun_clr2", 0, 0, 0, 8'd5);
        step(10);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_out("ack_ignored_idle", 0, 0, 0, 8'd5);

        // 6: reset in PEND and in HOLD
        level_in = 1'b0; step();
        level_in = 1'b1; step();
        expect_out("pend_before_rst", 1, 1, 0, 8'd6);
        rst = 1'b1; step(); rst = 1'b0;
        expect_out("rst_in_pend", 0, 0, 0, 8'd0);
        step();                         // level held high counts as an edge
        expect_out("held_level_edge", 1, 1, 0, 8'd1);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_out("hold_before_rst", 0, 0, 0, 8'd1);
        step();
        rst = 1'b1; level_in = 1'b0; step();
        expect_out("rst_in_hold", 0, 0, 0, 8'd0);
        rst = 1'b0; step();
        level_in = 1'b1; step();        // accepted at once: FSM back in IDLE
        expect_out("idle_after_hold_rst", 1, 1, 0, 8'd1);
        rst = 1'b1; level_in = 1'b0; step(2);
        rst = 1'b0; step();

        // 5: 256 accepted events wrap event_cnt to 0
        for (int n = 1; n <= 256; n++) begin
            level_in = 1'b0; step();
            level_in = 1'b1; step();
            expect_out("wrap_evt", 1, 1, 0, 8'(n));
            int_ack = 1'b1; step(); int_ack = 1'b0;
            step(9);
        end
        expect_out("wrap_idle", 0, 0, 0, 8'd0);

        step(2);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d snapshots never compared", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
